// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: evaluates ALU flags, computes targets and link values,
// and sequences a registered PC redirect followed by a multi-cycle IF/ID flush.
module branch_resolve_unit #(
  parameter int N            = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic             zero_flag,
  input  logic             sign_flag,
  input  logic             overflow_flag,
  input  logic             carry_flag,
  input  logic [N-1:0]     pc,
  input  logic [N-1:0]     imm,
  input  logic [N-1:0]     alu_result,
  output logic             redirect_valid,
  output logic [N-1:0]     redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             link_valid,
  output logic [N-1:0]     link_data,
  output logic             misalign_exc,
  output logic             illegal_exc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int SQ_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } state_t;

  state_t          state_r, next_state_s;
  logic [SQ_W-1:0] sq_cnt_r, sq_cnt_next_s;

  logic          sel_jalr_s, sel_jal_s, sel_br_s;
  logic          cond_s, illegal_s, taken_s, accept_s, misalign_s, go_s;
  logic [N-1:0]  target_s;

  logic             redirect_valid_s, flush_s, link_valid_s, misalign_exc_s, illegal_exc_s;
  logic [N-1:0]     redirect_pc_s, link_data_s;
  logic [CNT_W-1:0] branch_cnt_s, taken_cnt_s;

  // Decode the control transfer (JALR > JAL > branch), its condition and its target.
  always_comb begin
    sel_jalr_s = is_jalr;
    sel_jal_s  = is_jal & ~is_jalr;
    sel_br_s   = is_branch & ~is_jal & ~is_jalr;
    cond_s     = 1'b0;
    illegal_s  = 1'b0;
    case (funct3)
      3'b000:  cond_s = zero_flag;
      3'b001:  cond_s = ~zero_flag;
      3'b100:  cond_s = sign_flag ^ overflow_flag;
      3'b101:  cond_s = ~(sign_flag ^ overflow_flag);
      3'b110:  cond_s = ~carry_flag;
      3'b111:  cond_s = carry_flag;
      default: illegal_s = 1'b1;
    endcase
    if (sel_jalr_s) begin
      target_s = {alu_result[N-1:1], 1'b0};
    end else begin
      target_s = pc + imm;
    end
    taken_s    = sel_jalr_s | sel_jal_s | (sel_br_s & cond_s);
    accept_s   = (state_r == IDLE) & in_valid & ~stall;
    misalign_s = taken_s & (target_s[1:0] != 2'b00);
    go_s       = accept_s & taken_s & ~misalign_s;
  end

  // State and squash-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      sq_cnt_r <= {SQ_W{1'b0}};
    end else begin
      state_r  <= next_state_s;
      sq_cnt_r <= sq_cnt_next_s;
    end
  end

  // Next-state logic; a stall freezes the sequence in place.
  always_comb begin
    next_state_s  = state_r;
    sq_cnt_next_s = sq_cnt_r;
    if (stall) begin
      next_state_s  = state_r;
      sq_cnt_next_s = sq_cnt_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (go_s) begin
            next_state_s  = REDIRECT;
            sq_cnt_next_s = SQ_W'(FLUSH_CYCLES - 1);
          end else begin
            next_state_s = IDLE;
          end
        end
        REDIRECT: begin
          if (FLUSH_CYCLES > 1) begin
            next_state_s = SQUASH;
          end else begin
            next_state_s = IDLE;
          end
        end
        SQUASH: begin
          if (sq_cnt_r <= SQ_W'(1)) begin
            next_state_s = IDLE;
          end else begin
            sq_cnt_next_s = sq_cnt_r - SQ_W'(1);
          end
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; pulses are only consumed on non-stalled cycles.
  always_comb begin
    redirect_valid_s = redirect_valid;
    redirect_pc_s    = redirect_pc;
    flush_s          = flush_if;
    link_valid_s     = link_valid;
    link_data_s      = link_data;
    misalign_exc_s   = misalign_exc;
    illegal_exc_s    = illegal_exc;
    branch_cnt_s     = branch_cnt;
    taken_cnt_s      = taken_cnt;
    if (stall) begin
      redirect_valid_s = redirect_valid;
    end else begin
      redirect_valid_s = (next_state_s == REDIRECT);
      flush_s          = (next_state_s != IDLE);
      misalign_exc_s   = accept_s & misalign_s;
      illegal_exc_s    = accept_s & sel_br_s & illegal_s;
      link_valid_s     = accept_s & (sel_jal_s | sel_jalr_s);
      if (go_s) begin
        redirect_pc_s = target_s;
      end else begin
        redirect_pc_s = redirect_pc;
      end
      if (accept_s & (sel_jal_s | sel_jalr_s)) begin
        link_data_s = pc + N'(4);
      end else begin
        link_data_s = link_data;
      end
      if (accept_s & sel_br_s & ~(&branch_cnt)) begin
        branch_cnt_s = branch_cnt + CNT_W'(1);
      end else begin
        branch_cnt_s = branch_cnt;
      end
      if (accept_s & sel_br_s & cond_s & ~(&taken_cnt)) begin
        taken_cnt_s = taken_cnt + CNT_W'(1);
      end else begin
        taken_cnt_s = taken_cnt;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= {N{1'b0}};
      flush_if       <= 1'b0;
      flush_id       <= 1'b0;
      link_valid     <= 1'b0;
      link_data      <= {N{1'b0}};
      misalign_exc   <= 1'b0;
      illegal_exc    <= 1'b0;
      branch_cnt     <= {CNT_W{1'b0}};
      taken_cnt      <= {CNT_W{1'b0}};
    end else begin
      redirect_valid <= redirect_valid_s;
      redirect_pc    <= redirect_pc_s;
      flush_if       <= flush_s;
      flush_id       <= flush_s;
      link_valid     <= link_valid_s;
      link_data      <= link_data_s;
      misalign_exc   <= misalign_exc_s;
      illegal_exc    <= illegal_exc_s;
      branch_cnt     <= branch_cnt_s;
      taken_cnt      <= taken_cnt_s;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

  localparam int N     = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n, in_valid, stall, is_branch, is_jal, is_jalr;
  logic [2:0] funct3;
  logic zero_flag, sign_flag, overflow_flag, carry_flag;
  logic [N-1:0] pc, imm, alu_result;
  logic redirect_valid, flush_if, flush_id, link_valid, misalign_exc, illegal_exc;
  logic [N-1:0] redirect_pc, link_data;
  logic [CNT_W-1:0] branch_cnt, taken_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int eb = 0;
  int et = 0;

  branch_resolve_unit #(.N(N), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .zero_flag(zero_flag), .sign_flag(sign_flag), .overflow_flag(overflow_flag),
    .carry_flag(carry_flag), .pc(pc), .imm(imm), .alu_result(alu_result),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .flush_id(flush_id), .link_valid(link_valid),
    .link_data(link_data), .misalign_exc(misalign_exc), .illegal_exc(illegal_exc),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    funct3 = 3'b000; zero_flag = 1'b0; sign_flag = 1'b0; overflow_flag = 1'b0;
    carry_flag = 1'b0; pc = 32'h0; imm = 32'h0; alu_result = 32'h0;
  endtask

  task automatic branch(input logic [2:0] f3, input logic [3:0] zsvc,
                        input logic [31:0] p, input logic [31:0] i);
    idle_in();
    in_valid = 1'b1; is_branch = 1'b1; funct3 = f3;
    zero_flag = zsvc[3]; sign_flag = zsvc[2]; overflow_flag = zsvc[1]; carry_flag = zsvc[0];
    pc = p; imm = i;
  endtask

  task automatic count(input bit taken);
    if (eb < 15) eb++;
    if (taken && et < 15) et++;
  endtask

  // {funct3, z, s, v, c, expected taken}
  logic [7:0] vecs [9] = '{
    {3'b000, 4'b0000, 1'b0}, {3'b001, 4'b0000, 1'b1}, {3'b001, 4'b1000, 1'b0},
    {3'b100, 4'b0100, 1'b1}, {3'b100, 4'b0110, 1'b0}, {3'b101, 4'b0010, 1'b0},
    {3'b101, 4'b0110, 1'b1}, {3'b111, 4'b0001, 1'b1}, {3'b111, 4'b0000, 1'b0}
  };

  initial begin
    logic [7:0] e;
    rst_n = 1'b0; stall = 1'b0;
    idle_in();
    repeat (2) tick();
    chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
    chk("rst_branch_cnt", {28'b0, branch_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // BEQ taken
    branch(3'b000, 4'b1000, 32'h100, 32'h20);
    tick(); idle_in(); count(1'b1);
    chk("beq_rv", {31'b0, redirect_valid}, 32'd1);
    chk("beq_pc", redirect_pc, 32'h120);
    chk("beq_flush", {30'b0, flush_if, flush_id}, 32'd3);
    chk("beq_bcnt", {28'b0, branch_cnt}, 32'd1);
    chk("beq_tcnt", {28'b0, taken_cnt}, 32'd1);
    tick();
    chk("beq_sq_rv", {31'b0, redirect_valid}, 32'd0);
    chk("beq_sq_flush", {30'b0, flush_if, flush_id}, 32'd3);
    tick();
    chk("beq_idle_flush", {30'b0, flush_if, flush_id}, 32'd0);

    // BLTU not taken, then taken with negative imm
    branch(3'b110, 4'b0001, 32'h40, 32'h10);
    tick(); idle_in(); count(1'b0);
    chk("bltu_nt_rv", {31'b0, redirect_valid}, 32'd0);
    chk("bltu_nt_flush", {31'b0, flush_if}, 32'd0);
    branch(3'b110, 4'b0000, 32'h40, 32'hFFFF_FFF8);
    tick(); idle_in(); count(1'b1);
    chk("bltu_t_rv", {31'b0, redirect_valid}, 32'd1);
    chk("bltu_t_pc", redirect_pc, 32'h38);
    repeat (2) tick();

    for (int k = 0; k < 9; k++) begin
      e = vecs[k];
      branch(e[7:5], e[4:1], 32'h200, 32'h10);
      tick(); idle_in(); count(e[0]);
      chk($sformatf("cond%0d_rv", k), {31'b0, redirect_valid}, {31'b0, e[0]});
      if (e[0]) begin
        chk($sformatf("cond%0d_pc", k), redirect_pc, 32'h210);
        repeat (2) tick();
      end
    end
    chk("tbl_bcnt", {28'b0, branch_cnt}, eb);
    chk("tbl_tcnt", {28'b0, taken_cnt}, et);

    // JALR misaligned target: exception, link, no redirect
    idle_in(); in_valid = 1'b1; is_jalr = 1'b1; alu_result = 32'h2003; pc = 32'h500;
    tick(); idle_in();
    chk("jalr_mis", {31'b0, misalign_exc}, 32'd1);
    chk("jalr_mis_rv", {31'b0, redirect_valid}, 32'd0);
    chk("jalr_lv", {31'b0, link_valid}, 32'd1);
    chk("jalr_ld", link_data, 32'h504);
    tick();
    chk("jalr_mis_clr", {30'b0, misalign_exc, link_valid}, 32'd0);

    // JAL aligned: redirect, link, counters untouched
    idle_in(); in_valid = 1'b1; is_jal = 1'b1; pc = 32'h600; imm = 32'h40;
    tick(); idle_in();
    chk("jal_rv", {31'b0, redirect_valid}, 32'd1);
    chk("jal_pc", redirect_pc, 32'h640);
    chk("jal_ld", link_data, 32'h604);
    chk("jal_tcnt", {28'b0, taken_cnt}, et);
    repeat (2) tick();

    // JALR wins over a simultaneous branch
    branch(3'b000, 4'b1000, 32'h700, 32'h4);
    is_jalr = 1'b1; alu_result = 32'h3001;
    tick(); idle_in();
    chk("prio_pc", redirect_pc, 32'h3000);
    chk("prio_bcnt", {28'b0, branch_cnt}, eb);
    repeat (2) tick();

    // Stall holds a pending redirect; wrong-path inputs ignored
    branch(3'b001, 4'b0000, 32'h700, 32'h100);
    tick(); count(1'b1);
    chk("stall_rv0", {31'b0, redirect_valid}, 32'd1);
    branch(3'b010, 4'b0000, 32'h800, 32'h4);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_rv_hold%0d", k), {31'b0, redirect_valid}, 32'd1);
      chk($sformatf("stall_pc_hold%0d", k), redirect_pc, 32'h800);
    end
    stall = 1'b0;
    tick();
    chk("stall_rel_rv", {31'b0, redirect_valid}, 32'd0);
    chk("stall_rel_flush", {31'b0, flush_id}, 32'd1);
    tick(); idle_in();
    chk("stall_done_flush", {31'b0, flush_if}, 32'd0);
    chk("stall_ill", {31'b0, illegal_exc}, 32'd0);
    chk("stall_bcnt", {28'b0, branch_cnt}, eb);

    // Illegal funct3, pulse held across a stall
    branch(3'b011, 4'b1111, 32'h900, 32'h8);
    tick(); idle_in(); count(1'b0);
    chk("ill_pulse", {31'b0, illegal_exc}, 32'd1);
    chk("ill_rv", {31'b0, redirect_valid}, 32'd0);
    stall = 1'b1;
    tick();
    chk("ill_hold", {31'b0, illegal_exc}, 32'd1);
    stall = 1'b0;
    tick();
    chk("ill_clr", {31'b0, illegal_exc}, 32'd0);

    // Saturation
    for (int k = 0; k < 20; k++) begin
      branch(3'b000, 4'b1000, 32'h0, 32'h8);
      tick(); idle_in(); count(1'b1);
      repeat (2) tick();
    end
    chk("sat_tcnt", {28'b0, taken_cnt}, 32'd15);
    chk("sat_bcnt", {28'b0, branch_cnt}, 32'd15);

    // Asynchronous reset in the middle of a squash
    branch(3'b000, 4'b1000, 32'h100, 32'h20);
    tick(); idle_in();
    tick();
    chk("prerst_flush", {31'b0, flush_if}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_flush", {30'b0, flush_if, flush_id}, 32'd0);
    chk("arst_pc", redirect_pc, 32'd0);
    chk("arst_cnt", {24'b0, branch_cnt, taken_cnt}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_rv", {31'b0, redirect_valid}, 32'd0);
    chk("post_rst_flush", {31'b0, flush_if}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
